// File: rtl/xor_share_arbiter_if.sv
// Bundles the requester side, the shared XOR unit connection and the response
// return path of xor_share_arbiter into a single port.
// The slave view belongs to the arbiter.
// The master view belongs to whatever surrounds it: the requesters, the XOR
// datapath and the response consumer.
interface xor_share_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      xu_a;
    logic [WIDTH-1:0]      xu_b;
    logic [WIDTH-1:0]      xu_y;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_y;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;
    logic [15:0]           txn_count;

    modport slave (
        input  req_valid, req_a, req_b, xu_y, rsp_ready,
        output req_ready, xu_a, xu_b, rsp_valid, rsp_y, rsp_id, busy, txn_count
    );

    modport master (
        output req_valid, req_a, req_b, xu_y, rsp_ready,
        input  req_ready, xu_a, xu_b, rsp_valid, rsp_y, rsp_id, busy, txn_count
    );
endinterface

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational WIDTH-bit XOR unit
// among NREQ requesters.
// Each transaction runs through three phases:
//   IDLE  grant one requester and capture its operands.
//   EXEC  the XOR unit settles on the captured operands.
//   RESP  the registered result is held until the consumer takes it.
module xor_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    xor_share_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant;
    logic             found;
    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [NREQ-1:0]  ready;

    logic [WIDTH-1:0] xu_a_q;
    logic [WIDTH-1:0] xu_b_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [15:0]      txn_count_q;

    // Scan the requesters starting one past the last winner.
    // The first one found valid is the round-robin pick.
    always_comb begin
        int             pos;
        logic [IDW-1:0] idx;
        found = 1'b0;
        grant = '0;
        pos   = 0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(last_grant) + k) % NREQ;
            idx = pos[IDW-1:0];
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // Route the winning requester's operands toward the capture registers.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a = bus.req_a[i*WIDTH +: WIDTH];
                sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept    = (state == IDLE) && found;
    assign handshake = (state == RESP) && rsp_valid_q && bus.rsp_ready;

    // The one-hot accept strobe is only offered while idle.
    // It is also gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        ready = '0;
        if (rst_n && accept) begin
            ready[grant] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // EXEC always lasts exactly one cycle.
    // RESP waits for the consumer handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found)         state_next = EXEC;
            EXEC:                       state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Capture the winner on accept: operands for the XOR unit, its id for the
    // response, and the rotation pointer.
    // The operands stay put until the next accept.
    // Resetting last_grant to NREQ-1 makes requester 0 the first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xu_a_q     <= '0;
            xu_b_q     <= '0;
            rsp_id_q   <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (accept) begin
            xu_a_q     <= sel_a;
            xu_b_q     <= sel_b;
            rsp_id_q   <= grant;
            last_grant <= grant;
        end
    end

    // Register the settled XOR result at the end of EXEC.
    // Present it until the consumer handshakes.
    // An asynchronous reset drops any in-flight result without counting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
        end else if (state == EXEC) begin
            rsp_valid_q <= 1'b1;
            rsp_y_q     <= bus.xu_y;
        end else if (handshake) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Count completed responses.
    // The counter wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_q <= '0;
        end else if (handshake) begin
            txn_count_q <= txn_count_q + 16'd1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.xu_a      = xu_a_q;
    assign bus.xu_b      = xu_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state != IDLE);
    assign bus.txn_count = txn_count_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed testbench for xor_share_arbiter.
// The bench models the shared XOR unit itself.
// Expected values are computed by hand from the operands driven.
module tb_xor_share_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic clk;
    logic rst_n;
    int   ntests;
    int   nfail;

    xor_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    xor_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared XOR datapath: purely combinational from the registered operands.
    assign bus.xu_y = bus.xu_a ^ bus.xu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_y3 [4];

    initial begin
        ntests        = 0;
        nfail         = 0;
        exp_y3[0]     = 8'hEE;
        exp_y3[1]     = 8'hDD;
        exp_y3[2]     = 8'hCC;
        exp_y3[3]     = 8'hBB;
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset held with every requester asking.
        tick();
        tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        chk("rst_txn",       32'(bus.txn_count), 32'h0);
        chk("rst_xu_a",      32'(bus.xu_a),      32'h0);
        chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
        bus.req_valid = 4'h0;
        #2;
        rst_n = 1'b1;

        // Single request from requester 0: A5 ^ 0F = AA.
        bus.req_valid    = 4'b0001;
        bus.req_a[7:0]   = 8'hA5;
        bus.req_b[7:0]   = 8'h0F;
        #1;
        chk("t2_ready", 32'(bus.req_ready), 32'h1);
        chk("t2_idle",  32'(bus.busy),      32'h0);
        tick();
        bus.req_valid = 4'h0;
        chk("t2_busy",      32'(bus.busy),      32'h1);
        chk("t2_ready_off", 32'(bus.req_ready), 32'h0);
        chk("t2_xu_a",      32'(bus.xu_a),      32'hA5);
        chk("t2_xu_b",      32'(bus.xu_b),      32'h0F);
        chk("t2_no_rsp",    32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t2_rsp_y",     32'(bus.rsp_y),     32'hAA);
        chk("t2_rsp_id",    32'(bus.rsp_id),    32'h0);
        tick();
        chk("t2_rsp_done",  32'(bus.rsp_valid), 32'h0);
        chk("t2_txn",       32'(bus.txn_count), 32'h1);
        chk("t2_busy_off",  32'(bus.busy),      32'h0);

        // Fresh reset, then all four requesting: grant order 0,1,2,3,0.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("t3_txn_rst", 32'(bus.txn_count), 32'h0);
        bus.req_a     = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_b     = 32'hFFFF_FFFF;
        bus.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_grant",      32'(bus.req_ready), 32'h1 << (k % 4));
            tick();
            chk("t3_ready_exec", 32'(bus.req_ready), 32'h0);
            tick();
            chk("t3_rsp_y",      32'(bus.rsp_y),     32'(exp_y3[k % 4]));
            chk("t3_rsp_id",     32'(bus.rsp_id),    32'(k % 4));
            tick();
            chk("t3_txn",        32'(bus.txn_count), 32'(k + 1));
        end

        // Requester 2 alone: 0011 ^ 0101 = 0110.
        bus.req_valid     = 4'b0100;
        bus.req_a[23:16]  = 8'b0000_0011;
        bus.req_b[23:16]  = 8'b0000_0101;
        #1;
        chk("t4_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'h0;
        tick();
        chk("t4_rsp_y",  32'(bus.rsp_y),     32'h06);
        chk("t4_rsp_id", 32'(bus.rsp_id),    32'h2);
        tick();
        chk("t4_txn",    32'(bus.txn_count), 32'h6);

        // Consumer back-pressure: 5A ^ FF = A5 from requester 1 held in RESP.
        bus.rsp_ready    = 1'b0;
        bus.req_valid    = 4'b0010;
        bus.req_a[15:8]  = 8'h5A;
        bus.req_b[15:8]  = 8'hFF;
        #1;
        chk("t5_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid    = 4'b1000;
        bus.req_a[31:24] = 8'hC3;
        bus.req_b[31:24] = 8'h3C;
        chk("t5_ready_exec", 32'(bus.req_ready), 32'h0);
        tick();
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t5_rsp_y",     32'(bus.rsp_y),     32'hA5);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t5_hold_valid", 32'(bus.rsp_valid), 32'h1);
            chk("t5_hold_y",     32'(bus.rsp_y),     32'hA5);
            chk("t5_hold_id",    32'(bus.rsp_id),    32'h1);
            chk("t5_hold_ready", 32'(bus.req_ready), 32'h0);
            chk("t5_hold_txn",   32'(bus.txn_count), 32'h6);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("t5_release",   32'(bus.rsp_valid), 32'h0);
        chk("t5_txn",       32'(bus.txn_count), 32'h7);
        chk("t5_next_gnt",  32'(bus.req_ready), 32'h8);

        // Reset during EXEC of requester 3: no response, priority back to 0.
        tick();
        chk("t6_exec_busy", 32'(bus.busy), 32'h1);
        chk("t6_exec_xu_a", 32'(bus.xu_a), 32'hC3);
        bus.req_valid = 4'hF;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(bus.req_ready), 32'h0);
        chk("t6_rst_rsp",   32'(bus.rsp_valid), 32'h0);
        chk("t6_rst_busy",  32'(bus.busy),      32'h0);
        chk("t6_rst_txn",   32'(bus.txn_count), 32'h0);
        chk("t6_rst_xu_a",  32'(bus.xu_a),      32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t6_grant0", 32'(bus.req_ready), 32'h1);
        chk("t6_no_rsp", 32'(bus.rsp_valid), 32'h0);
        tick();
        tick();
        chk("t6_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("t6_rsp_y",  32'(bus.rsp_y),  32'hEE);
        tick();
        chk("t6_txn",    32'(bus.txn_count), 32'h1);
        bus.req_valid = 4'h0;
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
